// File: rtl/exe_stage.sv
// exe_stage: execute stage between ID and MEM (ALU, MULT/MULTU, DIV/DIVU, HI/LO).
// Optional: ES_DIV_ZERO_SKIP_EN makes a zero-divisor divide finish at once.
// Ports:
//  clk, resetn              clock, synchronous active-low reset
//  ds_to_es_valid/_bus      instruction offered by ID (164-bit bundle)
//  es_allowin, ms_allowin   handshake with ID and MEM
//  es_to_ms_valid/_bus      instruction handed to MEM (77-bit bundle)
//  data_sram_*              data SRAM request, issued in the handoff cycle
//  es_fwd_blk_bus           {blk, fwd_valid[3:0], dest, result} to ID
module exe_stage #(
  parameter logic [31:0] HILO_RST_VAL = 32'h0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ms_allowin,
  output logic         es_allowin,
  input  logic         ds_to_es_valid,
  input  logic [163:0] ds_to_es_bus,
  output logic         es_to_ms_valid,
  output logic [76:0]  es_to_ms_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [41:0]  es_fwd_blk_bus
);

  typedef enum logic [1:0] {
    D_IDLE, D_RUN, D_DONE
  } dstate_t;

  logic         es_valid_q;
  logic [163:0] bus_q;

  logic [31:0] pc, src1, src2, rt;
  logic [4:0]  dest;
  logic        gr_we, rfm, mem_we;
  logic [1:0]  st_size;
  logic [5:0]  ld;
  logic [11:0] alu_op;
  logic [7:0]  hl;

  assign pc      = bus_q[31:0];
  assign src2    = bus_q[63:32];
  assign src1    = bus_q[95:64];
  assign dest    = bus_q[100:96];
  assign gr_we   = bus_q[101];
  assign rfm     = bus_q[102];
  assign mem_we  = bus_q[103];
  assign st_size = bus_q[105:104];
  assign ld      = bus_q[111:106];
  assign alu_op  = bus_q[123:112];
  assign hl      = bus_q[131:124];
  assign rt      = bus_q[163:132];

  logic is_div, is_mul, leave, ready_go;
  assign is_div = hl[0] | hl[1];
  assign is_mul = hl[2] | hl[3];

  // ALU
  logic [31:0] alu_res;
  logic [32:0] sub_w;
  assign sub_w = {1'b0, src1} - {1'b0, src2};

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      alu_op[0]:  alu_res = src1 + src2;
      alu_op[1]:  alu_res = sub_w[31:0];
      alu_op[2]:  alu_res = {31'h0, $signed(src1) < $signed(src2)};
      alu_op[3]:  alu_res = {31'h0, sub_w[32]};
      alu_op[4]:  alu_res = src1 & src2;
      alu_op[5]:  alu_res = ~(src1 | src2);
      alu_op[6]:  alu_res = src1 | src2;
      alu_op[7]:  alu_res = src1 ^ src2;
      alu_op[8]:  alu_res = src2 << src1[4:0];
      alu_op[9]:  alu_res = src2 >> src1[4:0];
      alu_op[10]: alu_res = $signed(src2) >>> src1[4:0];
      alu_op[11]: alu_res = {src2[15:0], 16'h0};
      default:    alu_res = '0;
    endcase
  end

  // Low 64 bits of the extended product serve both signed and unsigned.
  logic        ext1, ext2;
  logic [63:0] prod;
  assign ext1 = hl[2] & src1[31];
  assign ext2 = hl[2] & src2[31];
  assign prod = {{32{ext1}}, src1} * {{32{ext2}}, src2};

  // Divider
  dstate_t     st_q, st_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        sq_q, sq_d, sr_q, sr_d;
  logic [31:0] abs1, abs2, quot, remv;
  logic [32:0] tmp, diff;
  logic        zskip;

`ifdef ES_DIV_ZERO_SKIP_EN
  assign zskip = (src2 == 32'h0);
`else
  assign zskip = 1'b0;
`endif

  assign abs1 = (hl[0] & src1[31]) ? -src1 : src1;
  assign abs2 = (hl[0] & src2[31]) ? -src2 : src2;
  assign tmp  = {rem_q, dvd_q[31]};
  assign diff = tmp - {1'b0, dvs_q};
  assign quot = sq_q ? -dvd_q : dvd_q;
  assign remv = sr_q ? -rem_q : rem_q;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    sq_d  = sq_q;
    sr_d  = sr_q;
    unique case (st_q)
      D_IDLE: begin
        if (es_valid_q & is_div) begin
          if (zskip) begin
            // Raw results, sign fix disabled.
            dvd_d = '1;
            rem_d = src1;
            sq_d  = 1'b0;
            sr_d  = 1'b0;
            st_d  = D_DONE;
          end else begin
            dvd_d = abs1;
            dvs_d = abs2;
            rem_d = '0;
            cnt_d = '0;
            sq_d  = hl[0] & (src1[31] ^ src2[31]);
            sr_d  = hl[0] & src1[31];
            st_d  = D_RUN;
          end
        end
      end
      D_RUN: begin
        // dvd shifts the dividend out and the quotient in.
        rem_d = diff[32] ? tmp[31:0] : diff[31:0];
        dvd_d = {dvd_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) st_d = D_DONE;
      end
      D_DONE: begin
        if (leave) st_d = D_IDLE;
      end
      default: st_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_q  <= D_IDLE;
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      sq_q  <= 1'b0;
      sr_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      sq_q  <= sq_d;
      sr_q  <= sr_d;
    end
  end

  // Handshake
  assign ready_go       = ~is_div | (st_q == D_DONE);
  assign es_allowin     = ~es_valid_q | (ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_q & ready_go;
  assign leave          = es_to_ms_valid & ms_allowin;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      bus_q      <= '0;
    end else if (es_allowin) begin
      es_valid_q <= ds_to_es_valid;
      if (ds_to_es_valid) bus_q <= ds_to_es_bus;
    end
  end

  // HI/LO update only as the instruction leaves.
  logic [31:0] hi_q, lo_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= HILO_RST_VAL;
      lo_q <= HILO_RST_VAL;
    end else if (leave) begin
      if (is_mul) begin
        hi_q <= prod[63:32];
        lo_q <= prod[31:0];
      end else if (is_div) begin
        hi_q <= remv;
        lo_q <= quot;
      end else if (hl[6]) begin
        hi_q <= src1;
      end else if (hl[7]) begin
        lo_q <= src1;
      end
    end
  end

  logic [31:0] es_result;
  assign es_result = hl[4] ? hi_q :
                     hl[5] ? lo_q : alu_res;

  assign es_to_ms_bus = {ld, rfm, gr_we, dest,
                         es_result, pc};

  // Memory request
  logic [3:0]  wen;
  logic [31:0] wdata;

  assign data_sram_en = es_valid_q & ms_allowin
                      & (rfm | mem_we);

  always_comb begin
    wen   = 4'h0;
    wdata = {4{rt[7:0]}};
    unique case (st_size)
      2'd2: begin
        wen   = 4'hF;
        wdata = rt;
      end
      2'd1: begin
        wen   = alu_res[1] ? 4'hC : 4'h3;
        wdata = {2{rt[15:0]}};
      end
      default: begin
        wen   = 4'h1 << alu_res[1:0];
        wdata = {4{rt[7:0]}};
      end
    endcase
    if (!(mem_we & data_sram_en)) wen = 4'h0;
  end

  assign data_sram_wen   = wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = wdata;

  // Loads block ID: their data only exists after MEM.
  logic fwd;
  assign fwd = es_valid_q & gr_we;
  assign es_fwd_blk_bus = {fwd & rfm, {4{fwd}},
                           dest, es_result};

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors for exe_stage.
// Hand-computed expectations for ALU, MUL/DIV, HI/LO, SRAM and forwarding.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         resetn, ms_allowin, es_allowin;
  logic         ds_to_es_valid, es_to_ms_valid;
  logic [163:0] ds_to_es_bus;
  logic [76:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic [41:0]  es_fwd_blk_bus;

  localparam logic [31:0] RV = 32'h1234_5678;

  exe_stage #(.HILO_RST_VAL(RV)) dut (
    .clk(clk),
    .resetn(resetn),
    .ms_allowin(ms_allowin),
    .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid),
    .ds_to_es_bus(ds_to_es_bus),
    .es_to_ms_valid(es_to_ms_valid),
    .es_to_ms_bus(es_to_ms_bus),
    .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .es_fwd_blk_bus(es_fwd_blk_bus)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] ADD     = 12'h001;
  localparam logic [7:0]  H_NONE  = 8'h00;
  localparam logic [7:0]  H_DIV   = 8'h01;
  localparam logic [7:0]  H_DIVU  = 8'h02;
  localparam logic [7:0]  H_MULT  = 8'h04;
  localparam logic [7:0]  H_MULTU = 8'h08;
  localparam logic [7:0]  H_MFHI  = 8'h10;
  localparam logic [7:0]  H_MFLO  = 8'h20;
  localparam logic [7:0]  H_MTHI  = 8'h40;

`ifdef ES_DIV_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [163:0] mk(
    input logic [31:0] s1, input logic [31:0] s2,
    input logic [4:0] dst, input logic gw,
    input logic rfm, input logic mw,
    input logic [1:0] sz, input logic [11:0] op,
    input logic [7:0] h, input logic [31:0] rt);
    mk = {rt, h, op, 6'b0, sz, mw, rfm, gw,
          dst, s1, s2, 32'hBFC0_0000};
  endfunction

  task automatic issue(input logic [163:0] b);
    @(negedge clk);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while (!es_to_ms_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic rd(input logic [7:0] h,
                    input string tag,
                    input logic [31:0] exp);
    issue(mk(0, 0, 5'd2, 1'b1, 1'b0, 1'b0,
             2'd0, 12'h0, h, 0));
    chk(tag, es_to_ms_bus[63:32], exp);
  endtask

  task automatic divide(input logic [7:0] h,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int lat,
                        input string tag,
                        input logic [31:0] q,
                        input logic [31:0] r);
    int n;
    issue(mk(a, b, 5'd0, 1'b0, 1'b0, 1'b0,
             2'd0, 12'h0, h, 0));
    wait_go(n);
    chk({tag, " lat"}, n, lat);
    rd(H_MFLO, {tag, " lo"}, q);
    rd(H_MFHI, {tag, " hi"}, r);
  endtask

  initial begin
    int n;
    int pulses;
    resetn         = 1'b0;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", es_to_ms_valid, 0);
    chk("rst allowin", es_allowin, 1);
    chk("rst en", data_sram_en, 0);
    chk("rst fwd", es_fwd_blk_bus, 0);
    @(negedge clk);
    resetn = 1'b1;

    rd(H_MFHI, "rst hi", RV);
    rd(H_MFLO, "rst lo", RV);

    // divu 100/7, with stall check during the divide
    issue(mk(100, 7, 5'd0, 1'b0, 1'b0, 1'b0,
             2'd0, 12'h0, H_DIVU, 0));
    chk("div stall allowin", es_allowin, 0);
    chk("div stall valid", es_to_ms_valid, 0);
    wait_go(n);
    chk("divu lat", n, 33);
    rd(H_MFLO, "divu lo", 32'd14);
    rd(H_MFHI, "divu hi", 32'd2);

    divide(H_DIV, 32'hFFFF_FFF9, 32'd2, 33,
           "div -7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    divide(H_DIV, 32'd7, 32'hFFFF_FFFE, 33,
           "div 7/-2", 32'hFFFF_FFFD, 32'd1);

    issue(mk(32'hFFFF_FFFF, 2, 5'd0, 1'b0, 1'b0,
             1'b0, 2'd0, 12'h0, H_MULT, 0));
    rd(H_MFHI, "mult hi", 32'hFFFF_FFFF);
    rd(H_MFLO, "mult lo", 32'hFFFF_FFFE);
    issue(mk(32'hFFFF_FFFF, 2, 5'd0, 1'b0, 1'b0,
             1'b0, 2'd0, 12'h0, H_MULTU, 0));
    rd(H_MFHI, "multu hi", 32'd1);
    rd(H_MFLO, "multu lo", 32'hFFFF_FFFE);

    issue(mk(32'h0000_AABB, 0, 5'd0, 1'b0, 1'b0,
             1'b0, 2'd0, 12'h0, H_MTHI, 0));
    rd(H_MFHI, "mthi", 32'h0000_AABB);

    // sb with MEM stalled for three cycles
    @(negedge clk);
    @(posedge clk);
    #1;
    ms_allowin = 1'b0;
    issue(mk(32'h1000, 2, 5'd0, 1'b0, 1'b0, 1'b1,
             2'd0, ADD, H_NONE, 32'h1122_3344));
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (data_sram_en) pulses++;
      @(posedge clk);
      #1;
    end
    chk("sb hold en", pulses, 0);
    @(negedge clk);
    ms_allowin = 1'b1;
    #1;
    chk("sb en", data_sram_en, 1);
    chk("sb wen", data_sram_wen, 4'h4);
    chk("sb wdata", data_sram_wdata, 32'h4444_4444);
    chk("sb addr", data_sram_addr, 32'h1002);
    @(posedge clk);
    #1;
    chk("sb en after", data_sram_en, 0);

    issue(mk(32'h1000, 2, 5'd0, 1'b0, 1'b0, 1'b1,
             2'd1, ADD, H_NONE, 32'h1122_3344));
    chk("sh wen", data_sram_wen, 4'hC);
    chk("sh wdata", data_sram_wdata, 32'h3344_3344);

    issue(mk(32'h2000, 4, 5'd5, 1'b1, 1'b1, 1'b0,
             2'd2, ADD, H_NONE, 0));
    chk("lw fwd", es_fwd_blk_bus,
        {1'b1, 4'hF, 5'd5, 32'h2004});
    chk("lw en", data_sram_en, 1);
    chk("lw wen", data_sram_wen, 4'h0);
    issue(mk(1, 2, 5'd3, 1'b1, 1'b0, 1'b0,
             2'd0, ADD, H_NONE, 0));
    chk("add fwd", es_fwd_blk_bus,
        {1'b0, 4'hF, 5'd3, 32'd3});
    chk("add valid", es_to_ms_valid, 1);

    // reset at RUN step 10 abandons the divide
    issue(mk(100, 7, 5'd0, 1'b0, 1'b0, 1'b0,
             2'd0, 12'h0, H_DIVU, 0));
    repeat (11) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("mid rst valid", es_to_ms_valid, 0);
    chk("mid rst allowin", es_allowin, 1);
    @(negedge clk);
    resetn = 1'b1;
    rd(H_MFHI, "mid rst hi", RV);
    rd(H_MFLO, "mid rst lo", RV);
    divide(H_DIV, 32'd100, 32'd7, 33,
           "div 100/7", 32'd14, 32'd2);

    divide(H_DIV, 32'd5, 32'd0, ZLAT,
           "div 5/0", 32'hFFFF_FFFF, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
